// File: rtl/ysyx_23060184_wbq.sv
// Write-back queue: selects a result source at enqueue and buffers {result, rd, we}
// entries in FIFO order, then presents the head entry to the register-file write port.
module ysyx_23060184_wbq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NSRC        = 4,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned RADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SEL_WIDTH-1:0]            in_sel,
    input  logic [NSRC*DATA_WIDTH-1:0]      in_src,
    input  logic [RADDR_WIDTH-1:0]          in_rd,
    input  logic                            in_we,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            rf_we,
    output logic [RADDR_WIDTH-1:0]          rf_waddr,
    output logic [DATA_WIDTH-1:0]           rf_wdata,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            sel_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [RADDR_WIDTH-1:0] rd;
        logic                   we;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sel_err_q, sel_err_d;

    logic               enq;
    logic               deq;
    logic               sel_illegal;
    logic [DATA_WIDTH-1:0] result;
    entry_t             head;

    // Result source mux; out-of-range selects yield zero data.
    always_comb begin
        result = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            if (in_sel == SEL_WIDTH'(k)) begin
                result = in_src[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_illegal = (32'(in_sel) >= NSRC);

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;

    assign head      = mem_q[rptr_q];
    assign rf_waddr  = head.rd;
    assign rf_wdata  = head.data;
    assign rf_we     = deq && head.we && (head.rd != '0);
    assign count     = count_q;
    assign sel_err   = sel_err_q;

    // Next-state for pointers, occupancy and the illegal-select pulse.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        sel_err_d = enq && sel_illegal;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (deq) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            sel_err_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wptr_q] <= '{data: result, rd: in_rd, we: in_we};
        end
    end

endmodule
